mem_fetch_unit: RTL and testbench
=================================

Name: mem_fetch_unit

Overview:
Memory-access stage between the 16-bit unified memory and the multicycle controller.
- On a start pulse, performs either a two-beat instruction fetch or a single-beat data read/write through a req/ack memory handshake.
- A fetch assembles one 32-bit instruction register (IR) and decodes its fields for the controller.
- A data read fills the memory data register (MDR).
- A per-beat wait-state timeout flags a dead memory.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory word width (IR = 2*DATA_W)
TIMEOUT, 15, maximum wait cycles per beat before abort (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
start  in  1  begin transaction; sampled only in IDLE
IorD  in  1  0 = instruction fetch at pc, 1 = data access at alu_addr
Memwrite  in  1  1 = data write (IorD=1 only; ignored on a fetch)
pc  in  ADDR_W  instruction address
alu_addr  in  ADDR_W  data address
wdata  in  DATA_W  store data
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
mem_ack  in  1  memory acknowledge
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  timeout flag
instr  out  2*DATA_W  IR
opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
funct  out  6  instr[5:0]
imm  out  16  instr[15:0]
mdr  out  DATA_W  memory data register

Behaviour:
- Reset (rst=0 at an edge): state IDLE. mem_req, mem_we, done, err = 0. mem_addr, mem_wdata, instr, mdr and the staging register = 0. Wait counter = 0. Reset overrides any in-flight beat; no partial IR update.
- States: IDLE, F_HI, F_LO, D_ACC.
- Start latch: in IDLE with start=1, latch IorD, Memwrite, pc, alu_addr, wdata and clear err.
  - IorD=0 -> F_HI.
  - IorD=1 -> D_ACC.
  - Callers may change inputs after the start edge.
- Start while busy is ignored.
- Start in the same cycle that done=1 is accepted, since the unit is back in IDLE.
- Handshake:
  - mem_req, mem_addr, mem_we and mem_wdata are registered and stay stable while the unit is in F_HI, F_LO or D_ACC.
  - A beat completes at the first rising edge where mem_req=1 and mem_ack=1; mem_rdata is captured at that edge.
  - mem_ack while mem_req=0 is ignored.
  - Zero-wait ack (ack in the first req cycle) is legal.
- F_HI: mem_addr = pc, mem_we = 0. On ack, staging <= mem_rdata (upper half) -> F_LO.
- F_LO:
  - mem_addr = pc + 1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - On ack: instr <= {staging, mem_rdata}, atomically; state -> IDLE, done=1.
- D_ACC: mem_addr = alu_addr, mem_we = Memwrite, mem_wdata = wdata. On ack:
  - read: mdr <= mem_rdata;
  - write: mdr unchanged;
  - then -> IDLE, done=1.
- mem_req and mem_we drop to 0 in the cycle after the final ack.
- Timeout:
  - The wait counter clears at every beat entry and counts each cycle with mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT: abort to IDLE with err=1 and done=1, and mem_req=0.
  - instr and mdr are unchanged; staging is discarded.
  - err stays high until the next accepted start.
- Latency with zero-wait memory: fetch done 3 cycles after the start edge; data access done 2 cycles after.
- Decoded fields are combinational slices of instr and change only when instr updates.

Test Plan:
- Reset then fetch: pc=0x0010, memory[0x0010]=0x8C22, memory[0x0011]=0x0004, zero-wait. Required: mem_addr 0x0010 then 0x0011; done 3 cycles after start; instr=0x8C220004, opcode=0x23, rs=1, rt=2, imm=0x0004; busy low after done.
- Wait states: fetch with ack delayed 3 cycles per beat. Required: mem_req and mem_addr stable throughout; done at cycle 9; instr correct.
- Data read/write:
  - alu_addr=0x0100, Memwrite=1, wdata=0xBEEF: one write beat with mem_we=1, mdr unchanged.
  - Then a read of 0x0100: mdr=0xBEEF, done 2 cycles after start.
- Timeout: TIMEOUT=4, fetch with ack never asserted. Required: abort after 4 wait cycles with err=1, done=1; instr keeps its previous value; the next start clears err.
- Boundaries:
  - pc=0xFFFF: second beat uses address 0x0000.
  - start pulsed mid-fetch: ignored.
  - start in the done cycle: accepted.
- Reset mid-operation: rst=0 during F_LO. Required: next cycle IDLE, mem_req=0, instr=0, err=0.

Source files
------------

// File: rtl/mem_fetch_unit.sv
// Memory-access stage: two-beat 32-bit instruction fetch or single-beat data
// read/write over a req/ack memory port, with a per-beat wait-state timeout.
module mem_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                IorD,
  input  logic                Memwrite,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2*DATA_W-1:0] instr,
  output logic [5:0]          opcode,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [5:0]          funct,
  output logic [15:0]         imm,
  output logic [DATA_W-1:0]   mdr
);

  localparam logic [7:0]        WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    F_HI  = 2'd1,
    F_LO  = 2'd2,
    D_ACC = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   stage_q, stage_d;
  logic [2*DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          wait_q, wait_d;

  logic beat_done;
  logic wait_expired;

  assign beat_done    = req_q & mem_ack;
  assign wait_expired = req_q & ~mem_ack & (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      stage_q <= '0;
      instr_q <= '0;
      mdr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      stage_q <= stage_d;
      instr_q <= instr_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    stage_d = stage_q;
    instr_d = instr_q;
    mdr_d   = mdr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    wait_d  = wait_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d  = 1'b0;
          pc_d   = pc;
          wait_d = '0;
          req_d  = 1'b1;
          if (!IorD) begin
            state_d = F_HI;
            we_d    = 1'b0;
            addr_d  = pc;
          end else begin
            state_d = D_ACC;
            we_d    = Memwrite;
            addr_d  = alu_addr;
            wdata_d = wdata;
          end
        end
      end
      F_HI: begin
        if (beat_done) begin
          stage_d = mem_rdata;
          addr_d  = pc_q + ADDR_ONE;
          wait_d  = '0;
          state_d = F_LO;
        end
      end
      F_LO: begin
        // Both halves land in IR on the same edge so the decode never sees a torn word.
        if (beat_done) begin
          instr_d = {stage_q, mem_rdata};
          state_d = IDLE;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      D_ACC: begin
        if (beat_done) begin
          if (!we_q) begin
            mdr_d = mem_rdata;
          end
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort fires on the edge of the TIMEOUT-th unacknowledged request cycle.
    if (state_q != IDLE && !beat_done) begin
      if (wait_expired) begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b1;
        err_d   = 1'b1;
        stage_d = '0;
        wait_d  = '0;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign instr     = instr_q;
  assign mdr       = mdr_q;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign funct  = instr_q[5:0];
  assign imm    = instr_q[15:0];

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Scoreboard bench for mem_fetch_unit: stimulus queues expected beats and
// completions, negedge monitors pop and compare against the DUT.
module tb_mem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        IorD = 1'b0;
  logic        Memwrite = 1'b0;
  logic [15:0] pc = 16'h0;
  logic [15:0] alu_addr = 16'h0;
  logic [15:0] wdata = 16'h0;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, err;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm, mdr;

  mem_fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .IorD(IorD), .Memwrite(Memwrite),
    .pc(pc), .alu_addr(alu_addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err), .instr(instr),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .mdr(mdr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] instr;
    logic [15:0] mdr;
    int          done_cyc;
  } resp_t;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wd;
  } beat_t;

  resp_t resp_q[$];
  beat_t beat_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    txn = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: ack after ack_delay wait cycles per beat, or never.
  logic [15:0] mem [0:65535];
  int          ack_delay = 0;
  bit          ack_never = 1'b0;
  int          rcnt = 0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] <= 16'h0;
    mem[16'h0010] <= 16'h8C22;
    mem[16'h0011] <= 16'h0004;
    mem[16'h0020] <= 16'h1234;
    mem[16'h0021] <= 16'h5678;
    mem[16'hFFFF] <= 16'hABCD;
    mem[16'h0000] <= 16'h0123;
  end

  assign mem_ack   = mem_req && !ack_never && (rcnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_req || mem_ack) rcnt <= 0;
    else rcnt <= rcnt + 1;
    if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Completion monitor
  resp_t mon_r;
  always @(negedge clk) begin
    if (rst && done) begin
      if (resp_q.size() == 0) begin
        fail_now("unexpected_done", "done pulsed with nothing outstanding");
      end else begin
        mon_r = resp_q.pop_front();
        txn++;
        chk("done_cycle", 32'(cyc + 1), 32'(mon_r.done_cyc));
        chk("err", {31'h0, err}, {31'h0, mon_r.err});
        chk("instr", instr, mon_r.instr);
        chk("opcode", {26'h0, opcode}, {26'h0, mon_r.instr[31:26]});
        chk("rs", {27'h0, rs}, {27'h0, mon_r.instr[25:21]});
        chk("rt", {27'h0, rt}, {27'h0, mon_r.instr[20:16]});
        chk("rd", {27'h0, rd}, {27'h0, mon_r.instr[15:11]});
        chk("funct", {26'h0, funct}, {26'h0, mon_r.instr[5:0]});
        chk("imm", {16'h0, imm}, {16'h0, mon_r.instr[15:0]});
        chk("mdr", {16'h0, mdr}, {16'h0, mon_r.mdr});
        chk("busy_at_done", {31'h0, busy}, 32'h0);
        $display("txn %0d: done at cycle %0d err=%0b instr=0x%08h mdr=0x%04h",
                 txn, cyc + 1, err, instr, mdr);
      end
    end
  end

  // Beat monitor plus request-stability check
  beat_t       mon_b;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  always @(negedge clk) begin
    if (rst && mem_req && mem_ack) begin
      if (beat_q.size() == 0) begin
        fail_now("unexpected_beat", $sformatf("beat at addr 0x%04h we=%0b", mem_addr, mem_we));
      end else begin
        mon_b = beat_q.pop_front();
        chk("beat_addr", {16'h0, mem_addr}, {16'h0, mon_b.addr});
        chk("beat_we", {31'h0, mem_we}, {31'h0, mon_b.we});
        if (mon_b.we) chk("beat_wdata", {16'h0, mem_wdata}, {16'h0, mon_b.wd});
      end
    end
    if (rst && mem_req && prev_req && !prev_ack) begin
      chk("req_addr_stable", {16'h0, mem_addr}, {16'h0, prev_addr});
      chk("req_we_stable", {31'h0, mem_we}, {31'h0, prev_we});
    end
    prev_req  <= mem_req;
    prev_ack  <= mem_ack;
    prev_addr <= mem_addr;
    prev_we   <= mem_we;
  end

  // Called at a negedge with the unit idle (or in its done cycle).
  task automatic issue(input logic iord, input logic mw, input logic [15:0] a,
                       input logic [15:0] wd, input int lat, input int nbeats,
                       input bit expect_done, input logic e_err,
                       input logic [31:0] e_instr, input logic [15:0] e_mdr);
    beat_t b;
    resp_t r;
    if (nbeats >= 1) begin
      b.addr = a;
      b.we   = iord ? mw : 1'b0;
      b.wd   = wd;
      beat_q.push_back(b);
    end
    if (nbeats >= 2) begin
      b.addr = a + 16'd1;
      b.we   = 1'b0;
      b.wd   = wd;
      beat_q.push_back(b);
    end
    IorD = iord; Memwrite = mw; pc = a; alu_addr = a; wdata = wd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; IorD = ~iord; Memwrite = ~mw; pc = ~a; alu_addr = ~a; wdata = ~wd;
    @(negedge clk);
    if (expect_done) begin
      r.err = e_err; r.instr = e_instr; r.mdr = e_mdr; r.done_cyc = cyc + lat;
      resp_q.push_back(r);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) fail_now(name, "no done within 100 cycles");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_mdr", {16'h0, mdr}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait fetch
    ack_delay = 0;
    issue(1'b0, 1'b0, 16'h0010, 16'h0, 3, 2, 1'b1, 1'b0, 32'h8C220004, 16'h0000);
    wait_done("fetch0");
    repeat (2) @(negedge clk);

    // Three wait states per beat
    ack_delay = 3;
    issue(1'b0, 1'b0, 16'h0020, 16'h0, 9, 2, 1'b1, 1'b0, 32'h12345678, 16'h0000);
    wait_done("fetch_wait");
    @(negedge clk);

    // Write then read back, read issued in the write's done cycle
    ack_delay = 0;
    issue(1'b1, 1'b1, 16'h0100, 16'hBEEF, 2, 1, 1'b1, 1'b0, 32'h12345678, 16'h0000);
    wait_done("write");
    issue(1'b1, 1'b0, 16'h0100, 16'h0000, 2, 1, 1'b1, 1'b0, 32'h12345678, 16'hBEEF);
    wait_done("read");

    // Dead memory: abort after 4 wait cycles
    ack_never = 1'b1;
    issue(1'b0, 1'b0, 16'h0010, 16'h0, 5, 0, 1'b1, 1'b1, 32'h12345678, 16'hBEEF);
    wait_done("timeout");
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'h0, err}, 32'h1);
    ack_never = 1'b0;

    // Wrapping fetch at 0xFFFF; start clears err
    issue(1'b0, 1'b0, 16'hFFFF, 16'h0, 3, 2, 1'b1, 1'b0, 32'hABCD0123, 16'hBEEF);
    chk("err_cleared", {31'h0, err}, 32'h0);
    wait_done("fetch_wrap");
    repeat (2) @(negedge clk);

    // Start pulsed mid-fetch must be ignored
    ack_delay = 2;
    issue(1'b0, 1'b0, 16'h0010, 16'h0, 7, 2, 1'b1, 1'b0, 32'h8C220004, 16'hBEEF);
    @(negedge clk);
    IorD = 1'b1; Memwrite = 1'b1; alu_addr = 16'h0100; wdata = 16'hDEAD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("fetch_midstart");
    ack_delay = 0;
    issue(1'b1, 1'b0, 16'h0100, 16'h0000, 2, 1, 1'b1, 1'b0, 32'h8C220004, 16'hBEEF);
    wait_done("read_after_ignored");
    repeat (2) @(negedge clk);

    // Reset during F_LO
    ack_delay = 3;
    issue(1'b0, 1'b0, 16'h0020, 16'h0, 0, 1, 1'b0, 1'b0, 32'h0, 16'h0);
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 16'h0021) && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!(mem_req && mem_addr == 16'h0021)) fail_now("reach_f_lo", "second beat never started");
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_err", {31'h0, err}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Normal operation after reset
    ack_delay = 0;
    issue(1'b0, 1'b0, 16'h0010, 16'h0, 3, 2, 1'b1, 1'b0, 32'h8C220004, 16'h0000);
    wait_done("fetch_after_rst");

    repeat (5) @(negedge clk);
    chk("resp_queue_empty", 32'(resp_q.size()), 32'h0);
    chk("beat_queue_empty", 32'(beat_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
